// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the matrix-keypad entry block:
//               scanner state encoding, code/column widths and the row-line
//               decoder used to recognise a single pressed key.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

   // Width of one decoded key code ({row, col})
   localparam int KEY_W    = 4;
   // Number of keypad columns and rows driven / sensed
   localparam int NUM_COLS = 4;
   localparam int COL_W    = 2;
   localparam int ROW_W    = 2;

   // Scanner state machine encoding
   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // Result of looking at the active-low row lines for the current column
   typedef struct packed {
      logic             valid;
      logic [ROW_W-1:0] idx;
   } row_dec_t;

   // Exactly one low row is a key; all-high or multiple lows are "no key"
   function automatic row_dec_t decode_rows(input logic [3:0] rows_n);
      row_dec_t d;
      d = '{valid: 1'b1, idx: 2'd0};
      case (rows_n)
         4'b1110: d.idx = 2'd0;
         4'b1101: d.idx = 2'd1;
         4'b1011: d.idx = 2'd2;
         4'b0111: d.idx = 2'd3;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_entry_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick_gen
// Description : Free-running prescaler. Counts 0..SCAN_DIV-1 and raises a
//               one-cycle tick while the count sits at SCAN_DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
   parameter int SCAN_DIV = 50000
) (
   input  logic Clk,
   input  logic Reset,
   output logic o_tick
);

   localparam int              CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == C_LAST);
   assign o_tick = w_last;

   // Prescaler count, wrapping to zero after the tick cycle
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry
// Description : 4x4 active-low matrix keypad scanner. Synchronises the row
//               lines, debounces press and release over scan ticks, decodes
//               the accepted key to a hex code and shifts it into a 16-bit
//               entry register (newest digit in [3:0]).
//               Optional build macro KEYPAD_REPEAT_EN: auto-repeat of a held
//               key every REPEAT_SCANS ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 8,
   parameter int REPEAT_SCANS   = 250
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [3:0]       rows_n,
   input  logic             clear,
   output logic [3:0]       col_n,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic [15:0]      value
);

   // Counter sized for the larger of the two tick limits; it only ever
   // counts up to a limit and is then reloaded, so it never wraps.
   localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] C_DEB = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CNT_W-1:0] C_REP = CNT_W'(REPEAT_SCANS);
`endif

   // Synchroniser
   logic [3:0]       r_sync1;
   logic [3:0]       r_rs_n;

   // Scanner state
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [KEY_W-1:0] r_cand;
   logic [KEY_W-1:0] w_cand_nxt;
   logic [COL_W-1:0] r_col_idx;
   logic [COL_W-1:0] w_col_nxt;

   // Accept path
   logic             w_accept;
   logic [KEY_W-1:0] w_acc_code;

   // Output registers
   logic [KEY_W-1:0] r_key_code;
   logic             r_key_valid;
   logic [15:0]      r_value;

   // Decode helpers
   logic             w_tick;
   row_dec_t         w_dec;
   logic [KEY_W-1:0] w_code_now;
   logic             w_cand_low;
   logic             w_same_key;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .Clk    (Clk),
      .Reset  (Reset),
      .o_tick (w_tick)
   );

   assign w_dec      = decode_rows(r_rs_n);
   assign w_code_now = {w_dec.idx, r_col_idx};
   assign w_cand_low = ~r_rs_n[r_cand[KEY_W-1:COL_W]];
   assign w_same_key = w_dec.valid && (w_dec.idx == r_cand[KEY_W-1:COL_W]);
   assign w_cnt_inc  = r_cnt + C_ONE;

   assign col_n     = ~(4'b0001 << r_col_idx);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign value     = r_value;

   // Two-flop synchroniser on the asynchronous row lines (idle = all high)
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sync1 <= 4'hF;
         r_rs_n  <= 4'hF;
      end else begin
         r_sync1 <= rows_n;
         r_rs_n  <= r_sync1;
      end
   end

   // Scanner state, debounce counter, candidate code and column index
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= SCAN;
         r_cnt     <= '0;
         r_cand    <= '0;
         r_col_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cand    <= w_cand_nxt;
         r_col_idx <= w_col_nxt;
      end
   end

   // Next-state logic; everything moves only on a scan tick
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_col_nxt   = r_col_idx;
      w_accept    = 1'b0;
      w_acc_code  = r_cand;

      if (w_tick) begin
         case (r_state)
            SCAN: begin
               if (w_dec.valid) begin
                  w_cand_nxt = w_code_now;
                  if (C_ONE >= C_DEB) begin
                     // Single-tick debounce: the detecting tick is enough
                     w_accept    = 1'b1;
                     w_acc_code  = w_code_now;
                     w_cnt_nxt   = '0;
                     w_state_nxt = HELD;
                  end else begin
                     w_cnt_nxt   = C_ONE;
                     w_state_nxt = DEBOUNCE;
                  end
               end else begin
                  w_col_nxt = r_col_idx + 1'b1;
               end
            end

            DEBOUNCE: begin
               if (w_same_key) begin
                  if (w_cnt_inc >= C_DEB) begin
                     w_accept    = 1'b1;
                     w_cnt_nxt   = '0;
                     w_state_nxt = HELD;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  // Bounce or ghost: drop the candidate, keep the column
                  w_cnt_nxt   = '0;
                  w_state_nxt = SCAN;
               end
            end

            HELD: begin
               if (!w_cand_low) begin
                  if (C_ONE >= C_DEB) begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = SCAN;
                  end else begin
                     w_cnt_nxt   = C_ONE;
                     w_state_nxt = RELEASE;
                  end
               end
`ifdef KEYPAD_REPEAT_EN
               else if (w_cnt_inc >= C_REP) begin
                  w_accept  = 1'b1;
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
`endif
            end

            RELEASE: begin
               if (!w_cand_low) begin
                  if (w_cnt_inc >= C_DEB) begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = SCAN;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  // Key came back: restart the release count, no new accept
                  w_cnt_nxt = '0;
               end
            end

            default: begin
               w_cnt_nxt   = '0;
               w_state_nxt = SCAN;
            end
         endcase
      end
   end

   // Accept strobe, last key code and the shifting entry register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
         r_value     <= 16'h0000;
      end else begin
         r_key_valid <= w_accept;
         if (w_accept) begin
            r_key_code <= w_acc_code;
         end
         if (clear) begin
            r_value <= w_accept ? {12'h000, w_acc_code} : 16'h0000;
         end else if (w_accept) begin
            r_value <= {r_value[11:0], w_acc_code};
         end
      end
   end

endmodule
`default_nettype wire
